// File: rtl/mul_add_16x51_pkg.sv
// Shared widths, vector types and a reference model for the Q*B + R
// shift-add multiply-accumulate pipeline.
package mul_add_pkg;

  localparam int unsigned WQ  = 16;
  localparam int unsigned WB  = 51;
  localparam int unsigned WP  = WQ + WB + 1;
  localparam int unsigned LAT = WQ + 1;

  typedef logic [WQ-1:0] q_t;
  typedef logic [WB-1:0] b_t;
  typedef logic [WP-1:0] p_t;

  // Reference result at full product width; WP bits cannot overflow.
  function automatic p_t golden_mul_add(input q_t q, input b_t b, input b_t r);
    return p_t'(q) * p_t'(b) + p_t'(r);
  endfunction

endpackage

// File: rtl/mul_add_16x51_if.sv
// Operand/result bundle for mul_add_16x51: valid-qualified operands in,
// valid-qualified product out, no backpressure.
interface mul_add_16x51_if;
  import mul_add_pkg::*;

  logic vin;
  q_t   Q;
  b_t   B;
  b_t   R;
  logic vout;
  p_t   Pout;

  modport master (
    output vin, Q, B, R,
    input  vout, Pout
  );

  modport slave (
    input  vin, Q, B, R,
    output vout, Pout
  );

endinterface

// File: rtl/mul_add_16x51_stage.sv
// One registered shift-add step: consumes the current multiplier MSB,
// doubles the accumulator and adds the multiplicand when that bit is set.
module mul_add_stage
  import mul_add_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  p_t   acc_i,
  input  q_t   q_i,
  input  b_t   b_i,
  input  b_t   r_i,
  input  logic v_i,
  output p_t   acc_o,
  output q_t   q_o,
  output b_t   b_o,
  output b_t   r_o,
  output logic v_o
);

  p_t   acc_q, acc_d;
  q_t   q_q, q_d;
  b_t   b_q, r_q;
  logic v_q;

  always_comb begin
    acc_d = acc_i << 1;
    if (q_i[WQ-1]) begin
      acc_d = acc_d + p_t'(b_i);
    end
    q_d = {q_i[WQ-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      q_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      v_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      q_q   <= q_d;
      b_q   <= b_i;
      r_q   <= r_i;
      v_q   <= v_i;
    end
  end

  assign acc_o = acc_q;
  assign q_o   = q_q;
  assign b_o   = b_q;
  assign r_o   = r_q;
  assign v_o   = v_q;

endmodule

// File: rtl/mul_add_16x51.sv
// Pipelined unsigned Q*B + R: capture register, WQ shift-add stages (MSB
// first), then a final remainder add. Latency WQ+1, one result per clock.
module mul_add_16x51
  import mul_add_pkg::*;
(
  input logic           clk,
  input logic           reset,
  mul_add_16x51_if.slave bus
);

  p_t   acc0_q;
  q_t   q0_q;
  b_t   b0_q, r0_q;
  logic v0_q;

  p_t   acc_s [1:WQ];
  q_t   q_s   [1:WQ];
  b_t   b_s   [1:WQ];
  b_t   r_s   [1:WQ];
  logic v_s   [1:WQ];

  p_t   pout_q, pout_d;
  logic vout_q;

  // Operands are captured every cycle; vin only rides alongside them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc0_q <= '0;
      q0_q   <= '0;
      b0_q   <= '0;
      r0_q   <= '0;
      v0_q   <= 1'b0;
    end else begin
      acc0_q <= '0;
      q0_q   <= bus.Q;
      b0_q   <= bus.B;
      r0_q   <= bus.R;
      v0_q   <= bus.vin;
    end
  end

  genvar i;
  for (i = 1; i <= int'(WQ); i++) begin : g_stage
    p_t   acc_in;
    q_t   q_in;
    b_t   b_in, r_in;
    logic v_in;

    if (i == 1) begin : g_first
      assign acc_in = acc0_q;
      assign q_in   = q0_q;
      assign b_in   = b0_q;
      assign r_in   = r0_q;
      assign v_in   = v0_q;
    end else begin : g_rest
      assign acc_in = acc_s[i-1];
      assign q_in   = q_s[i-1];
      assign b_in   = b_s[i-1];
      assign r_in   = r_s[i-1];
      assign v_in   = v_s[i-1];
    end

    mul_add_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .acc_i (acc_in),
      .q_i   (q_in),
      .b_i   (b_in),
      .r_i   (r_in),
      .v_i   (v_in),
      .acc_o (acc_s[i]),
      .q_o   (q_s[i]),
      .b_o   (b_s[i]),
      .r_o   (r_s[i]),
      .v_o   (v_s[i])
    );
  end

  always_comb begin
    pout_d = acc_s[WQ] + p_t'(r_s[WQ]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pout_q <= '0;
      vout_q <= 1'b0;
    end else begin
      pout_q <= pout_d;
      vout_q <= v_s[WQ];
    end
  end

  assign bus.Pout = pout_q;
  assign bus.vout = vout_q;

endmodule

// File: tb/tb_mul_add_16x51.sv
// Directed + random bench for mul_add_16x51 with an expected-result queue
// aligned to the 17-edge pipeline latency.
module tb_mul_add_16x51;

  localparam int LAT = 17;

  typedef struct packed {
    logic        v;
    logic        chk;
    logic [67:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_add_16x51_if bus();

  mul_add_16x51 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t  sb[$];
  string sb_tag[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    step_no = 0;

  function automatic logic [67:0] gold(input logic [15:0] q, input logic [50:0] b,
                                       input logic [50:0] r);
    logic [67:0] t;
    t = 68'(q) * 68'(b);
    return t + 68'(r);
  endfunction

  task automatic compare_out(input string tag, input exp_t e);
    n_cmp++;
    assert (bus.vout === e.v) else begin
      n_bad++;
      $error("FAIL %s.vout step=%0d observed=%b expected=%b", tag, step_no, bus.vout, e.v);
    end
    if (e.chk) begin
      n_cmp++;
      assert (bus.Pout === e.p) else begin
        n_bad++;
        $error("FAIL %s.Pout step=%0d observed=%h expected=%h", tag, step_no, bus.Pout, e.p);
      end
    end
  endtask

  // Drive one operand set, clock it in, then check whatever leaves the pipe.
  task automatic step(input string tag, input logic v, input logic [15:0] q,
                      input logic [50:0] b, input logic [50:0] r,
                      input logic chk, input logic [67:0] p);
    exp_t e;
    bus.vin = v;
    bus.Q   = q;
    bus.B   = b;
    bus.R   = r;
    @(posedge clk);
    step_no++;
    e.v   = v;
    e.chk = chk;
    e.p   = p;
    sb.push_back(e);
    sb_tag.push_back(tag);
    #1;
    if (sb.size() > LAT) compare_out(sb_tag.pop_front(), sb.pop_front());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 1'b0, '0, '0, '0, 1'b1, '0);
  endtask

  // After reset every pipeline register is zero: expect LAT zero outputs.
  task automatic prefill_after_reset();
    exp_t z;
    z.v = 1'b0; z.chk = 1'b1; z.p = '0;
    sb.delete();
    sb_tag.delete();
    for (int k = 0; k < LAT; k++) begin
      sb.push_back(z);
      sb_tag.push_back("flush");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        zero_e;
    logic [63:0] r64;
    logic [50:0] rb, rr, rb2;
    logic [15:0] rq;
    logic [67:0] a68, lim;

    zero_e.v = 1'b0; zero_e.chk = 1'b1; zero_e.p = '0;

    reset   = 1'b0;
    bus.vin = 1'b0;
    bus.Q   = '0;
    bus.B   = '0;
    bus.R   = '0;
    repeat (2) @(posedge clk);
    #1;
    compare_out("reset", zero_e);
    #3 reset = 1'b1;
    prefill_after_reset();

    step("basic", 1'b1, 16'h1234, 51'd5, 51'd3, 1'b1, 68'h5B07);
    idle(20);

    step("max", 1'b1, 16'hFFFF, 51'h7_FFFF_FFFF_FFFF, 51'h7_FFFF_FFFF_FFFF, 1'b1,
         68'h7_FFFF_FFFF_FFFF_0000);
    step("zero_q", 1'b1, 16'h0000, 51'h7_ABCD_EF01_2345, 51'h42, 1'b1, 68'h42);
    step("zero_b", 1'b1, 16'hFFFF, 51'h0, 51'h0, 1'b1, 68'h0);
    idle(LAT);

    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        r64 = {$urandom, $urandom}; rb = r64[50:0];
        r64 = {$urandom, $urandom}; rr = r64[50:0];
        rq  = 16'($urandom);
        step("gap", 1'b0, rq, rb, rr, 1'b0, '0);
      end
      r64 = {$urandom, $urandom}; rb = r64[50:0];
      r64 = {$urandom, $urandom}; rr = r64[50:0];
      rq  = 16'($urandom);
      step("stream", 1'b1, rq, rb, rr, 1'b1, gold(rq, rb, rr));
    end
    idle(LAT);

    // Visible result at reset time, plus five in-flight operations to discard.
    step("pre_rst", 1'b1, 16'hA5A5, 51'h1_2345_6789_ABCD, 51'h77, 1'b1,
         gold(16'hA5A5, 51'h1_2345_6789_ABCD, 51'h77));
    idle(9);
    for (int n = 0; n < 5; n++) begin
      rq = 16'(n + 1) * 16'h1111;
      rb = 51'(n + 3) * 51'h3_0000_0001;
      step("inflight", 1'b1, rq, rb, 51'h5, 1'b1, gold(rq, rb, 51'h5));
    end
    idle(3);
    #3 reset = 1'b0;
    #1 compare_out("arst_now", zero_e);
    @(posedge clk);
    #1 compare_out("arst_hold", zero_e);
    #2 reset = 1'b1;
    prefill_after_reset();
    step("post_rst", 1'b1, 16'h00F0, 51'h123, 51'h9, 1'b1, gold(16'h00F0, 51'h123, 51'h9));
    idle(LAT + 3);

    for (int n = 0; n < 50; n++) begin
      r64 = {$urandom, $urandom};
      rb2 = r64[50:0];
      if (rb2 == '0) rb2 = 51'd1;
      r64 = {$urandom, $urandom};
      lim = 68'(rb2) << 16;
      a68 = 68'(r64) % lim;
      rq  = 16'(a68 / 68'(rb2));
      rr  = 51'(a68 % 68'(rb2));
      step("roundtrip", 1'b1, rq, rb2, rr, 1'b1, a68);
    end
    idle(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
